// File: rtl/aht10_ctrl.sv
// aht10_ctrl: AHT10 humidity/temperature sequencer driving a byte-level i2c_master.
// Power-up delay, calibration init, periodic trigger, conversion wait, 6-byte readout.
// Optional: define AHT10_BUSY_POLL_EN to re-read (every POLL_MS) while status bit 7 (busy)
// is set, publishing only a non-busy readout.

`ifndef CMD_START
`define CMD_START 4'b0001
`endif
`ifndef CMD_WRITE
`define CMD_WRITE 4'b0010
`endif
`ifndef CMD_READ
`define CMD_READ 4'b0100
`endif
`ifndef CMD_STOP
`define CMD_STOP 4'b1000
`endif

module aht10_ctrl #(
  parameter int unsigned CYC_PER_MS = 50000,
  parameter int unsigned PWRUP_MS   = 40,
  parameter int unsigned CONV_MS    = 80,
  parameter int unsigned PERIOD_MS  = 1000,
  parameter int unsigned POLL_MS    = 10,
  parameter logic [6:0]  DEV_ADDR   = 7'h38
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meas_en,
  output logic        req,
  output logic [3:0]  cmd,
  output logic [7:0]  din,
  input  logic [7:0]  dout,
  input  logic        done,
  input  logic        slave_ack,
  output logic [19:0] hum_raw,
  output logic [19:0] tmp_raw,
  output logic [7:0]  status,
  output logic        data_vld,
  output logic        nack_err
);

  localparam int unsigned MAX_A  = (PWRUP_MS > CONV_MS) ? PWRUP_MS : CONV_MS;
  localparam int unsigned MAX_B  = (PERIOD_MS > POLL_MS) ? PERIOD_MS : POLL_MS;
  localparam int unsigned MAX_MS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MS_W   = (MAX_MS > 0) ? $clog2(MAX_MS + 1) : 1;
  localparam int unsigned CYC_W  = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam int unsigned IDX_W  = 3;
  localparam logic [7:0]  ADDR_WR = {DEV_ADDR, 1'b0};
  localparam logic [7:0]  ADDR_RD = {DEV_ADDR, 1'b1};

  typedef enum logic [2:0] {
    S_PWRUP   = 3'd0,
    S_INIT    = 3'd1,
    S_PERIOD  = 3'd2,
    S_TRIG    = 3'd3,
    S_CONV    = 3'd4,
    S_READ    = 3'd5,
    S_PUBLISH = 3'd6,
    S_POLL    = 3'd7
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [MS_W-1:0]    ms_cnt;
  logic [MS_W-1:0]    ms_tgt;
  logic               tick;
  logic               ms_hit;
  logic               enter;
  logic [IDX_W-1:0]   idx;
  logic               pend;
  logic [7:0]         shadow [6];

  logic               script_st;
  logic               issue;
  logic               byte_done;
  logic               last_byte;
  logic               wr_byte;
  logic               nack_c;
  logic               publish_ok;
  logic [3:0]         scr_cmd;
  logic [7:0]         scr_din;

  logic               req_d;
  logic [3:0]         cmd_d;
  logic [7:0]         din_d;
  logic [19:0]        hum_d;
  logic [19:0]        tmp_d;
  logic [7:0]         status_d;
  logic               vld_d;
  logic               nack_d;

  // Handshake qualifiers for the byte-script states
  always_comb begin
    script_st = (state == S_INIT) || (state == S_TRIG) || (state == S_READ);
    issue     = script_st && !pend;
    byte_done = script_st && pend && done;
    last_byte = (state == S_READ) ? (idx == IDX_W'(6)) : (idx == IDX_W'(3));
    wr_byte   = (state != S_READ) || (idx == IDX_W'(0));
    nack_c    = byte_done && wr_byte && slave_ack;
    tick      = (cyc_cnt == CYC_W'(CYC_PER_MS - 1));
    ms_hit    = (ms_cnt >= ms_tgt);
    enter     = (nxt != state);
  end

  // Delay target for the current state
  always_comb begin
    ms_tgt = '0;
    case (state)
      S_PWRUP:  ms_tgt = MS_W'(PWRUP_MS);
      S_PERIOD: ms_tgt = MS_W'(PERIOD_MS);
      S_CONV:   ms_tgt = MS_W'(CONV_MS);
      S_POLL:   ms_tgt = MS_W'(POLL_MS);
      default:  ms_tgt = '0;
    endcase
  end

  // Only a non-busy readout is published when busy polling is enabled
  always_comb begin
`ifdef AHT10_BUSY_POLL_EN
    publish_ok = (state == S_PUBLISH) && !shadow[0][7];
`else
    publish_ok = (state == S_PUBLISH);
`endif
  end

  // Byte script: command and data for the current state and byte index
  always_comb begin
    scr_cmd = '0;
    scr_din = '0;
    case (state)
      S_INIT: begin
        case (idx)
          IDX_W'(0): begin scr_cmd = `CMD_START | `CMD_WRITE; scr_din = ADDR_WR; end
          IDX_W'(1): begin scr_cmd = `CMD_WRITE;              scr_din = 8'hE1;   end
          IDX_W'(2): begin scr_cmd = `CMD_WRITE;              scr_din = 8'h08;   end
          default:   begin scr_cmd = `CMD_WRITE | `CMD_STOP;  scr_din = 8'h00;   end
        endcase
      end
      S_TRIG: begin
        case (idx)
          IDX_W'(0): begin scr_cmd = `CMD_START | `CMD_WRITE; scr_din = ADDR_WR; end
          IDX_W'(1): begin scr_cmd = `CMD_WRITE;              scr_din = 8'hAC;   end
          IDX_W'(2): begin scr_cmd = `CMD_WRITE;              scr_din = 8'h33;   end
          default:   begin scr_cmd = `CMD_WRITE | `CMD_STOP;  scr_din = 8'h00;   end
        endcase
      end
      S_READ: begin
        case (idx)
          IDX_W'(0): begin scr_cmd = `CMD_START | `CMD_WRITE; scr_din = ADDR_RD; end
          IDX_W'(6): begin scr_cmd = `CMD_READ | `CMD_STOP;   scr_din = 8'h00;   end
          default:   begin scr_cmd = `CMD_READ;               scr_din = 8'h00;   end
        endcase
      end
      default: begin
        scr_cmd = '0;
        scr_din = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_PWRUP;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_PWRUP:  if (ms_hit) nxt = S_INIT;
      S_INIT: begin
        if (nack_c)                      nxt = S_PWRUP;
        else if (byte_done && last_byte) nxt = S_PERIOD;
      end
      S_PERIOD: if (ms_hit && meas_en) nxt = S_TRIG;
      S_TRIG: begin
        if (nack_c)                      nxt = S_PERIOD;
        else if (byte_done && last_byte) nxt = S_CONV;
      end
      S_CONV:   if (ms_hit) nxt = S_READ;
      S_READ: begin
        if (nack_c)                      nxt = S_PERIOD;
        else if (byte_done && last_byte) nxt = S_PUBLISH;
      end
`ifdef AHT10_BUSY_POLL_EN
      S_PUBLISH: nxt = publish_ok ? S_PERIOD : S_POLL;
      S_POLL:    if (ms_hit) nxt = S_READ;
`else
      S_PUBLISH: nxt = S_PERIOD;
      S_POLL:    nxt = S_PERIOD;
`endif
      default:   nxt = S_PWRUP;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    req_d    = 1'b0;
    cmd_d    = '0;
    din_d    = '0;
    vld_d    = 1'b0;
    nack_d   = 1'b0;
    hum_d    = hum_raw;
    tmp_d    = tmp_raw;
    status_d = status;
    if (issue) begin
      req_d = 1'b1;
      cmd_d = scr_cmd;
      din_d = scr_din;
    end
    if (nack_c) nack_d = 1'b1;
    if (publish_ok) begin
      vld_d    = 1'b1;
      hum_d    = {shadow[1], shadow[2], shadow[3][7:4]};
      tmp_d    = {shadow[3][3:0], shadow[4], shadow[5]};
      status_d = shadow[0];
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req      <= 1'b0;
      cmd      <= '0;
      din      <= '0;
      hum_raw  <= '0;
      tmp_raw  <= '0;
      status   <= '0;
      data_vld <= 1'b0;
      nack_err <= 1'b0;
    end else begin
      req      <= req_d;
      cmd      <= cmd_d;
      din      <= din_d;
      hum_raw  <= hum_d;
      tmp_raw  <= tmp_d;
      status   <= status_d;
      data_vld <= vld_d;
      nack_err <= nack_d;
    end
  end

  // Cycle / millisecond counters, cleared on every state entry; ms saturates at target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ms_cnt  <= '0;
    end else if (enter) begin
      cyc_cnt <= '0;
      ms_cnt  <= '0;
    end else begin
      cyc_cnt <= tick ? '0 : cyc_cnt + CYC_W'(1);
      if (tick && !ms_hit) ms_cnt <= ms_cnt + MS_W'(1);
    end
  end

  // Byte index and waiting-for-done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      pend <= 1'b0;
    end else if (enter) begin
      idx  <= '0;
      pend <= 1'b0;
    end else if (byte_done) begin
      idx  <= idx + IDX_W'(1);
      pend <= 1'b0;
    end else if (issue) begin
      pend <= 1'b1;
    end
  end

  // Read-byte shadow: b0..b5 captured as each read byte completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) shadow[i] <= '0;
    end else if ((state == S_READ) && byte_done && (idx != IDX_W'(0))) begin
      shadow[idx - IDX_W'(1)] <= dout;
    end
  end

endmodule

// File: tb/tb_aht10_ctrl.sv
// tb_aht10_ctrl: directed sequence with randomized readout data and master latency,
// checked against a byte-level reference of the AHT10 transaction script.

module tb_aht10_ctrl;

  localparam int unsigned CYC  = 10;
  localparam int unsigned PWR  = 2;
  localparam int unsigned CONV = 3;
  localparam int unsigned PER  = 5;
  localparam int unsigned POLL = 2;
  localparam logic [3:0] C_S = 4'b0001;
  localparam logic [3:0] C_W = 4'b0010;
  localparam logic [3:0] C_R = 4'b0100;
  localparam logic [3:0] C_P = 4'b1000;

  logic        clk;
  logic        rst_n;
  logic        meas_en;
  logic        req;
  logic [3:0]  cmd;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        done;
  logic        slave_ack;
  logic [19:0] hum_raw;
  logic [19:0] tmp_raw;
  logic [7:0]  status;
  logic        data_vld;
  logic        nack_err;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int vld_cnt = 0;
  int nack_cnt = 0;
  int proto_err = 0;
  int rd_rd = 0;
  int nack_budget = 0;
  int nack_used = 0;
  logic [7:0] nack_byte = 8'h00;

  logic [3:0] lcmd [$];
  logic [7:0] ldin [$];
  int         lreq_t [$];
  int         ldone_t [$];
  logic [7:0] rd_q [$];

  aht10_ctrl #(
    .CYC_PER_MS(CYC), .PWRUP_MS(PWR), .CONV_MS(CONV),
    .PERIOD_MS(PER), .POLL_MS(POLL), .DEV_ADDR(7'h38)
  ) dut (
    .clk(clk), .rst_n(rst_n), .meas_en(meas_en),
    .req(req), .cmd(cmd), .din(din),
    .dout(dout), .done(done), .slave_ack(slave_ack),
    .hum_raw(hum_raw), .tmp_raw(tmp_raw), .status(status),
    .data_vld(data_vld), .nack_err(nack_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc_n = cyc_n + 1;
    end
  end

  // Pulse counters
  initial begin
    forever begin
      @(negedge clk);
      if (data_vld) vld_cnt = vld_cnt + 1;
      if (nack_err) nack_cnt = nack_cnt + 1;
    end
  end

  // Master/slave model: logs each request, answers with done after a random latency
  initial begin : responder
    logic [3:0] c;
    logic [7:0] d;
    int lat;
    bit aborted;
    done = 1'b0;
    dout = 8'h00;
    slave_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) rd_rd = rd_q.size();
      if (rst_n && req) begin
        c = cmd;
        d = din;
        lcmd.push_back(c);
        ldin.push_back(d);
        lreq_t.push_back(cyc_n);
        lat = int'($urandom_range(4, 1));
        aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          if (req) proto_err = proto_err + 1;
        end
        if (aborted) begin
          ldone_t.push_back(-1);
        end else begin
          if ((c & C_R) != 4'b0000) begin
            dout = (rd_rd < rd_q.size()) ? rd_q[rd_rd] : 8'h00;
            rd_rd = rd_rd + 1;
            slave_ack = 1'b0;
          end else begin
            dout = 8'h00;
            slave_ack = (nack_used < nack_budget) && (d == nack_byte);
            if (slave_ack) nack_used = nack_used + 1;
          end
          done = 1'b1;
          ldone_t.push_back(cyc_n);
          @(negedge clk);
          if (req) proto_err = proto_err + 1;
          done = 1'b0;
          slave_ack = 1'b0;
          dout = 8'h00;
        end
      end
    end
  end

  function automatic int fbyte(input logic [47:0] f, input int i);
    logic [47:0] s;
    s = f >> (8 * (5 - i));
    return int'(s & 48'hFF);
  endfunction

  function automatic logic [19:0] ref_hum(input logic [47:0] f);
    return 20'(fbyte(f, 1) * 4096 + fbyte(f, 2) * 16 + fbyte(f, 3) / 16);
  endfunction

  function automatic logic [19:0] ref_tmp(input logic [47:0] f);
    return 20'((fbyte(f, 3) % 16) * 65536 + fbyte(f, 4) * 256 + fbyte(f, 5));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) rd_q.push_back(8'(fbyte(f, i)));
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (ldin.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, 32'(ldin.size() >= n), 32'd1);
  endtask

  task automatic wait_vld(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (vld_cnt < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, 32'(vld_cnt), 32'(n));
  endtask

  task automatic expect_frame(input logic [47:0] f, input string tag);
    check({tag, "_hum"}, 32'(hum_raw), 32'(ref_hum(f)));
    check({tag, "_tmp"}, 32'(tmp_raw), 32'(ref_tmp(f)));
    check({tag, "_status"}, 32'(status), 32'(fbyte(f, 0)));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"}, 32'(req), 32'd0);
    check({tag, "_cmd"}, 32'(cmd), 32'd0);
    check({tag, "_din"}, 32'(din), 32'd0);
    check({tag, "_hum"}, 32'(hum_raw), 32'd0);
    check({tag, "_tmp"}, 32'(tmp_raw), 32'd0);
    check({tag, "_status"}, 32'(status), 32'd0);
    check({tag, "_vld"}, 32'(data_vld), 32'd0);
    check({tag, "_nack"}, 32'(nack_err), 32'd0);
  endtask

  function automatic logic [47:0] rand_frame();
    logic [47:0] f;
    f = 48'({$urandom(), $urandom()});
    f[47] = 1'b0;
    return f;
  endfunction

  initial begin : main
    int rel, base, n0, t, v0, starts, s2;
    logic [47:0] f, prev, f1, f2;

    rst_n = 1'b0;
    meas_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");

    // Power-up and calibration init
    rel = cyc_n;
    rst_n = 1'b1;
    wait_log(4, 400, "init_bytes_seen");
    check("first_req_cycle", 32'(lreq_t[0] - rel - 1), 32'd21);
    check("init0_cmd", 32'(lcmd[0]), 32'(C_S | C_W));
    check("init0_din", 32'(ldin[0]), 32'h70);
    check("init1_cmd", 32'(lcmd[1]), 32'(C_W));
    check("init1_din", 32'(ldin[1]), 32'hE1);
    check("init2_din", 32'(ldin[2]), 32'h08);
    check("init3_cmd", 32'(lcmd[3]), 32'(C_W | C_P));
    check("init3_din", 32'(ldin[3]), 32'h00);

    // First readout with fixed data
    f = 48'h1C_80_00_05_66_66;
    push_frame(f);
    wait_vld(1, 1500, "vld1");
    check("fixed_hum", 32'(hum_raw), 32'h80000);
    check("fixed_tmp", 32'(tmp_raw), 32'h56666);
    check("fixed_status", 32'(status), 32'h1C);
    check("log_len1", 32'(ldin.size()), 32'd15);
    check("trig0_din", 32'(ldin[4]), 32'h70);
    check("trig1_din", 32'(ldin[5]), 32'hAC);
    check("trig2_din", 32'(ldin[6]), 32'h33);
    check("trig3_cmd", 32'(lcmd[7]), 32'(C_W | C_P));
    check("read0_cmd", 32'(lcmd[8]), 32'(C_S | C_W));
    check("read0_din", 32'(ldin[8]), 32'h71);
    for (int i = 9; i < 14; i++) check("read_mid_cmd", 32'(lcmd[i]), 32'(C_R));
    check("read_last_cmd", 32'(lcmd[14]), 32'(C_R | C_P));
    t = lreq_t[8] - ldone_t[7];
    check("conv_gap", 32'(t >= int'(CONV * CYC) && t <= int'(CONV * CYC) + 4), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    check("vld_single", 32'(vld_cnt), 32'd1);
    prev = f;

    // Randomized readouts
    for (int r = 0; r < 3; r++) begin
      f = rand_frame();
      push_frame(f);
      wait_vld(2 + r, 1500, "vld_rand");
      expect_frame(f, "rand");
      prev = f;
    end

    // NACK on the 0xAC trigger byte
    n0 = ldin.size();
    nack_byte = 8'hAC;
    nack_budget = 1;
    t = 0;
    while (nack_cnt < 1 && t < 1500) begin
      @(negedge clk); #1;
      t++;
    end
    check("nack_pulse", 32'(nack_cnt), 32'd1);
    @(negedge clk); #1;
    check("nack_log_len", 32'(ldin.size()), 32'(n0 + 2));
    check("nack_byte", 32'(ldin[n0 + 1]), 32'hAC);
    check("nack_hum_hold", 32'(hum_raw), 32'(ref_hum(prev)));
    check("nack_status_hold", 32'(status), 32'(fbyte(prev, 0)));
    f = rand_frame();
    push_frame(f);
    wait_log(n0 + 3, 1000, "retrig_seen");
    check("retrig_din", 32'(ldin[n0 + 2]), 32'h70);
    t = lreq_t[n0 + 2] - ldone_t[n0 + 1];
    check("retrig_gap", 32'(t >= int'(PER * CYC) && t <= int'(PER * CYC) + 4), 32'd1);
    wait_vld(5, 1500, "vld_after_nack");
    expect_frame(f, "after_nack");
    check("nack_count_final", 32'(nack_cnt), 32'd1);

    // meas_en low holds the controller in period wait
    meas_en = 1'b0;
    n0 = ldin.size();
    repeat (5 * PER * CYC) @(negedge clk);
    #1;
    check("hold_no_req", 32'(ldin.size()), 32'(n0));
    f = rand_frame();
    push_frame(f);
    t = cyc_n;
    meas_en = 1'b1;
    wait_log(n0 + 1, 100, "resume_seen");
    check("resume_latency", 32'(lreq_t[n0] - t), 32'd2);
    check("resume_din", 32'(ldin[n0]), 32'h70);
    wait_vld(6, 1500, "vld_resume");
    expect_frame(f, "resume");

    // Busy status bit
    f1 = {8'h9C, 40'(rand_frame())};
    f2 = {8'h1C, 40'(rand_frame())};
    n0 = ldin.size();
    v0 = vld_cnt;
`ifdef AHT10_BUSY_POLL_EN
    push_frame(f1);
    push_frame(f2);
    wait_vld(v0 + 1, 2500, "vld_busy_poll");
    starts = 0;
    s2 = 0;
    for (int i = n0; i < ldin.size(); i++) begin
      if (ldin[i] == 8'h71) begin
        starts++;
        if (starts == 2) s2 = i;
      end
    end
    check("busy_read_starts", 32'(starts), 32'd2);
    expect_frame(f2, "busy_poll");
    if (s2 > 0) begin
      t = lreq_t[s2] - ldone_t[s2 - 1];
      check("poll_gap", 32'(t >= int'(POLL * CYC) && t <= int'(POLL * CYC) + 5), 32'd1);
    end
    repeat (5) @(negedge clk);
    #1;
    check("busy_vld_single", 32'(vld_cnt), 32'(v0 + 1));
`else
    push_frame(f1);
    wait_vld(v0 + 1, 1500, "vld_busy");
    check("busy_status", 32'(status), 32'h9C);
    expect_frame(f1, "busy");
    starts = 0;
    for (int i = n0; i < ldin.size(); i++) if (ldin[i] == 8'h71) starts++;
    check("busy_read_starts", 32'(starts), 32'd1);
    f2 = f1;
`endif

    // Reset during byte 3 of READ
    f = rand_frame();
    push_frame(f);
    n0 = ldin.size();
    v0 = vld_cnt;
    wait_log(n0 + 7, 1500, "read_byte3_seen");
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("midread_reset");
    repeat (3) @(negedge clk);
    #1;
    base = ldin.size();
    rel = cyc_n;
    rst_n = 1'b1;
    wait_log(base + 1, 400, "restart_seen");
    check("restart_req_cycle", 32'(lreq_t[base] - rel - 1), 32'd21);
    check("restart_cmd", 32'(lcmd[base]), 32'(C_S | C_W));
    check("restart_din", 32'(ldin[base]), 32'h70);
    check("restart_no_vld", 32'(vld_cnt), 32'(v0));
    check("protocol_errors", 32'(proto_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
